t9990_palette_ctrl: RTL and testbench

- Sequences CPU port P#1 palette traffic into the palette register's write and read strobe/ACK channels.
- Owns the palette pointer register (R#14): bits [7:2] select the palette entry, bits [1:0] select the component (0=R, 1=G, 2=B).
- Posts writes through a small FIFO so the CPU is not stalled while pixel fetches hold the palette RAM.
- Sits between the T9990 register/port decoder and the palette module; issues strobes only, never drives pixel-side signals.

---
 rtl/t9990_palette_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_t9990_palette_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t9990_palette_ctrl.sv
// T9990 palette port controller.
// Sequences CPU P#1 palette traffic into the palette write/read strobe-ACK channels and
// owns the palette pointer (R#14). Writes are posted through a small FIFO.
// Optional read prefetch buffer: define T9990_PAL_READ_PREFETCH_EN.
`timescale 1ns/1ps
module t9990_palette_ctrl #(
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       PTR_WE,
    input  logic [7:0] PTR_WDATA,
    output logic [7:0] PTR_RDATA,
    input  logic       RD_INC_EN,
    input  logic       CPU_WR,
    input  logic [7:0] CPU_WDATA,
    input  logic       CPU_RD,
    output logic [7:0] CPU_RDATA,
    output logic       CPU_RVALID,
    output logic       BUSY,
    output logic       OVERFLOW,
    output logic       PAL_W_STROBE,
    output logic [5:0] PAL_W_ADDR,
    output logic [1:0] PAL_W_PTR,
    output logic [5:0] PAL_W_DATA,
    input  logic       PAL_W_ACK,
    output logic       PAL_R_STROBE,
    output logic [5:0] PAL_R_ADDR,
    output logic [1:0] PAL_R_PTR,
    input  logic [5:0] PAL_R_DATA,
    input  logic       PAL_R_ACK
);

    localparam int unsigned AW = $clog2(WFIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StPf} state_e;

    state_e      state_q;
    logic [7:0]  ptr_q, ptr_d;
    logic        rd_pend_q;
    logic [7:0]  rd_tgt_q;

    // FIFO entry layout: {addr[13:8], comp[7:6], data[5:0]}
    logic [13:0]   fifo_mem [WFIFO_DEPTH];
    logic [AW-1:0] wr_idx_q, rd_idx_q;
    logic [AW:0]   count_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [13:0]   head;

    logic wr_acc, rd_take, rd_acc, pf_hit;
    logic unused_wdata;

    assign unused_wdata = ^CPU_WDATA[7:6];

    // Component 0..1 steps to the next component; 2 and 3 move to the next entry's R.
    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        if (p[1]) return {p[7:2] + 6'd1, 2'b00};
        else      return p + 8'd1;
    endfunction

    assign fifo_full  = (count_q == (AW+1)'(WFIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_idx_q];

    assign wr_acc  = CPU_WR && !fifo_full;
    assign rd_take = CPU_RD && !rd_pend_q;
    assign rd_acc  = rd_take && !pf_hit;
    assign push    = wr_acc;

    // Comp-3 head entries are discarded in a single idle cycle; others pop on write ACK.
    assign pop = ((state_q == StIdle) && !fifo_empty && (head[7:6] == 2'd3)) ||
                 ((state_q == StWr) && PAL_W_ACK);

    assign BUSY      = fifo_full | rd_pend_q;
    assign PTR_RDATA = ptr_q;

`ifdef T9990_PAL_READ_PREFETCH_EN
    logic       pf_valid_q, pf_kill_q;
    logic [7:0] pf_tag_q;
    logic [5:0] pf_data_q;
    logic       pf_inval;

    assign pf_hit   = rd_take && pf_valid_q && (pf_tag_q == ptr_q);
    assign pf_inval = PTR_WE || push || (ptr_d != ptr_q);
`else
    assign pf_hit = 1'b0;
`endif

    // Pointer next state: a pointer load wins over any access increment.
    always_comb begin
        ptr_d = ptr_q;
        if (PTR_WE) begin
            ptr_d = PTR_WDATA;
        end else if (wr_acc || (rd_take && RD_INC_EN)) begin
            ptr_d = ptr_inc(ptr_q);
        end
    end

    // Pointer register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) ptr_q <= 8'h00;
        else          ptr_q <= ptr_d;
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_idx_q] <= {ptr_q, CPU_WDATA[5:0]};
    end

    // FIFO indices and occupancy.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_idx_q <= wr_idx_q + AW'(1);
            if (pop)  rd_idx_q <= rd_idx_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Dropped-write indication.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) OVERFLOW <= 1'b0;
        else          OVERFLOW <= CPU_WR && fifo_full;
    end

    // Access sequencer with registered strobe/address/read-result outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= StIdle;
            rd_pend_q    <= 1'b0;
            rd_tgt_q     <= 8'h00;
            PAL_W_STROBE <= 1'b0;
            PAL_W_ADDR   <= 6'd0;
            PAL_W_PTR    <= 2'd0;
            PAL_W_DATA   <= 6'd0;
            PAL_R_STROBE <= 1'b0;
            PAL_R_ADDR   <= 6'd0;
            PAL_R_PTR    <= 2'd0;
            CPU_RDATA    <= 8'h00;
            CPU_RVALID   <= 1'b0;
`ifdef T9990_PAL_READ_PREFETCH_EN
            pf_valid_q   <= 1'b0;
            pf_kill_q    <= 1'b0;
            pf_tag_q     <= 8'h00;
            pf_data_q    <= 6'd0;
`endif
        end else begin
            CPU_RVALID <= 1'b0;
            if (rd_acc) begin
                rd_pend_q <= 1'b1;
                rd_tgt_q  <= ptr_q;
            end
`ifdef T9990_PAL_READ_PREFETCH_EN
            if (pf_inval) pf_valid_q <= 1'b0;
            if (pf_hit) begin
                CPU_RDATA  <= {2'b00, pf_data_q};
                CPU_RVALID <= 1'b1;
            end
`endif
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        if (head[7:6] != 2'd3) begin
                            PAL_W_STROBE <= 1'b1;
                            PAL_W_ADDR   <= head[13:8];
                            PAL_W_PTR    <= head[7:6];
                            PAL_W_DATA   <= head[5:0];
                            state_q      <= StWr;
                        end
                    end else if (rd_pend_q) begin
                        if (rd_tgt_q[1:0] == 2'd3) begin
                            CPU_RDATA  <= 8'h00;
                            CPU_RVALID <= 1'b1;
                            rd_pend_q  <= 1'b0;
                        end else begin
                            PAL_R_STROBE <= 1'b1;
                            PAL_R_ADDR   <= rd_tgt_q[7:2];
                            PAL_R_PTR    <= rd_tgt_q[1:0];
                            state_q      <= StRd;
                        end
                    end
`ifdef T9990_PAL_READ_PREFETCH_EN
                    else if (!pf_valid_q && !pf_inval && !rd_take) begin
                        pf_tag_q <= ptr_q;
                        if (ptr_q[1:0] == 2'd3) begin
                            pf_data_q  <= 6'd0;
                            pf_valid_q <= 1'b1;
                        end else begin
                            pf_kill_q    <= 1'b0;
                            PAL_R_STROBE <= 1'b1;
                            PAL_R_ADDR   <= ptr_q[7:2];
                            PAL_R_PTR    <= ptr_q[1:0];
                            state_q      <= StPf;
                        end
                    end
`endif
                end
                StWr: begin
                    if (PAL_W_ACK) begin
                        PAL_W_STROBE <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                StRd: begin
                    if (PAL_R_ACK) begin
                        PAL_R_STROBE <= 1'b0;
                        CPU_RDATA    <= {2'b00, PAL_R_DATA};
                        CPU_RVALID   <= 1'b1;
                        rd_pend_q    <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
`ifdef T9990_PAL_READ_PREFETCH_EN
                StPf: begin
                    // Any pointer disturbance during the fetch makes the result stale.
                    if (pf_inval) pf_kill_q <= 1'b1;
                    if (PAL_R_ACK) begin
                        PAL_R_STROBE <= 1'b0;
                        pf_data_q    <= PAL_R_DATA;
                        pf_valid_q   <= !pf_kill_q && !pf_inval;
                        state_q      <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_t9990_palette_ctrl.sv
// Scoreboard bench for t9990_palette_ctrl (default build, WFIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_t9990_palette_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       PTR_WE;
    logic [7:0] PTR_WDATA;
    logic [7:0] PTR_RDATA;
    logic       RD_INC_EN;
    logic       CPU_WR;
    logic [7:0] CPU_WDATA;
    logic       CPU_RD;
    logic [7:0] CPU_RDATA;
    logic       CPU_RVALID;
    logic       BUSY;
    logic       OVERFLOW;
    logic       PAL_W_STROBE;
    logic [5:0] PAL_W_ADDR;
    logic [1:0] PAL_W_PTR;
    logic [5:0] PAL_W_DATA;
    logic       PAL_W_ACK;
    logic       PAL_R_STROBE;
    logic [5:0] PAL_R_ADDR;
    logic [1:0] PAL_R_PTR;
    logic [5:0] PAL_R_DATA;
    logic       PAL_R_ACK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_wq [$];
    logic [5:0]  exp_rq [$];

    logic [5:0] pal_mem [256];
    logic       ack_en;
    logic       r_prev;
    time        last_w_ack, last_r_rise;

    t9990_palette_ctrl #(.WFIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .PTR_WE(PTR_WE), .PTR_WDATA(PTR_WDATA), .PTR_RDATA(PTR_RDATA),
        .RD_INC_EN(RD_INC_EN),
        .CPU_WR(CPU_WR), .CPU_WDATA(CPU_WDATA),
        .CPU_RD(CPU_RD), .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW),
        .PAL_W_STROBE(PAL_W_STROBE), .PAL_W_ADDR(PAL_W_ADDR), .PAL_W_PTR(PAL_W_PTR),
        .PAL_W_DATA(PAL_W_DATA), .PAL_W_ACK(PAL_W_ACK),
        .PAL_R_STROBE(PAL_R_STROBE), .PAL_R_ADDR(PAL_R_ADDR), .PAL_R_PTR(PAL_R_PTR),
        .PAL_R_DATA(PAL_R_DATA), .PAL_R_ACK(PAL_R_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Palette model: ACK one cycle after seeing a strobe, when enabled.
    assign PAL_R_DATA = pal_mem[{PAL_R_ADDR, PAL_R_PTR}];

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            PAL_W_ACK <= 1'b0;
            PAL_R_ACK <= 1'b0;
        end else begin
            PAL_W_ACK <= ack_en && PAL_W_STROBE && !PAL_W_ACK;
            PAL_R_ACK <= ack_en && PAL_R_STROBE && !PAL_R_ACK;
            if (PAL_W_STROBE && PAL_W_ACK) pal_mem[{PAL_W_ADDR, PAL_W_PTR}] <= PAL_W_DATA;
        end
    end

    // Output monitor: compare completed transactions against the scoreboard.
    always @(negedge CLK) begin
        if (RESET_n) begin
            if (PAL_W_STROBE && PAL_W_ACK) begin
                if (exp_wq.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    check("w_txn", {18'd0, PAL_W_ADDR, PAL_W_PTR, PAL_W_DATA},
                          {18'd0, exp_wq.pop_front()});
                end
                last_w_ack = $time;
            end
            if (PAL_R_STROBE && !r_prev) last_r_rise = $time;
            if (CPU_RVALID) begin
                if (exp_rq.size() == 0) begin
                    check("rvalid_unexpected", 1, 0);
                end else begin
                    check("rdata", {24'd0, CPU_RDATA}, {26'd0, exp_rq.pop_front()});
                end
            end
        end
        r_prev = PAL_R_STROBE;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ptr(input logic [7:0] v);
        PTR_WE = 1'b1; PTR_WDATA = v;
        tick();
        PTR_WE = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] d);
        CPU_WR = 1'b1; CPU_WDATA = d;
        tick();
        CPU_WR = 1'b0;
    endtask

    task automatic cpu_read();
        CPU_RD = 1'b1;
        tick();
        CPU_RD = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_wq.size() != 0 || exp_rq.size() != 0 || BUSY || PAL_W_STROBE ||
                PAL_R_STROBE) && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 200), 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) pal_mem[i] = 6'd0;
        r_prev = 1'b0; last_w_ack = 0; last_r_rise = 0;
        RESET_n = 1'b0; ack_en = 1'b1;
        PTR_WE = 1'b0; PTR_WDATA = 8'h00; RD_INC_EN = 1'b0;
        CPU_WR = 1'b0; CPU_WDATA = 8'h00; CPU_RD = 1'b0;
        repeat (3) tick();
        check("rst_ptr", PTR_RDATA, 8'h00);
        check("rst_busy", BUSY, 0);
        check("rst_rvalid", CPU_RVALID, 0);
        check("rst_rdata", CPU_RDATA, 8'h00);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_wstb", PAL_W_STROBE, 0);
        check("rst_rstb", PAL_R_STROBE, 0);
        RESET_n = 1'b1;
        tick();

        // Three writes walk R, G, B of entry 5.
        set_ptr(8'h14);
        exp_wq.push_back({6'd5, 2'd0, 6'h1F});
        exp_wq.push_back({6'd5, 2'd1, 6'h0A});
        exp_wq.push_back({6'd5, 2'd2, 6'h05});
        cpu_write(8'h1F); cpu_write(8'h0A); cpu_write(8'h05);
        check("ptr_after_rgb", PTR_RDATA, 8'h18);
        wait_idle();

        // Entry 63 wrap, and a component-3 write that never strobes.
        set_ptr(8'hFE);
        exp_wq.push_back({6'd63, 2'd2, 6'h2A});
        cpu_write(8'hEA);
        check("ptr_wrap", PTR_RDATA, 8'h00);
        set_ptr(8'h03);
        cpu_write(8'h11);
        check("ptr_comp3", PTR_RDATA, 8'h04);
        wait_idle();

        // Fill the FIFO with ACKs held off; the fifth write overflows.
        ack_en = 1'b0;
        set_ptr(8'h20);
        exp_wq.push_back({6'd8, 2'd0, 6'd1});
        exp_wq.push_back({6'd8, 2'd1, 6'd2});
        exp_wq.push_back({6'd8, 2'd2, 6'd3});
        exp_wq.push_back({6'd9, 2'd0, 6'd4});
        cpu_write(8'd1); cpu_write(8'd2); cpu_write(8'd3);
        check("busy_3", BUSY, 0);
        cpu_write(8'd4);
        check("busy_4", BUSY, 1);
        check("ovf_4", OVERFLOW, 0);
        cpu_write(8'd5);
        check("ovf_5", OVERFLOW, 1);
        check("ptr_drop", PTR_RDATA, 8'h25);
        tick();
        check("ovf_pulse", OVERFLOW, 0);
        ack_en = 1'b1;
        wait_idle();

        // Write then read of the same location: write first, read returns it.
        set_ptr(8'h08);
        exp_wq.push_back({6'd2, 2'd0, 6'h2D});
        cpu_write(8'hED);
        set_ptr(8'h08);
        exp_rq.push_back(6'h2D);
        cpu_read();
        wait_idle();
        check("w_before_r", 32'(last_w_ack < last_r_rise), 1);

        // Reads without auto-increment, including minimum latency.
        set_ptr(8'h09);
        exp_wq.push_back({6'd2, 2'd1, 6'h33});
        cpu_write(8'h33);
        wait_idle();
        set_ptr(8'h09);
        RD_INC_EN = 1'b0;
        exp_rq.push_back(6'h33);
        cpu_read();
        n = 0;
        while (!CPU_RVALID && n < 20) begin tick(); n++; end
        check("rd_latency", n, 3);
        wait_idle();
        exp_rq.push_back(6'h33);
        cpu_read();
        wait_idle();
        check("ptr_noinc", PTR_RDATA, 8'h09);
        RD_INC_EN = 1'b1;
        exp_rq.push_back(6'h33);
        cpu_read();
        check("ptr_inc", PTR_RDATA, 8'h0A);
        wait_idle();

        // Component-3 read: zero data, no strobe.
        set_ptr(8'h0B);
        exp_rq.push_back(6'h00);
        cpu_read();
        wait_idle();
        check("ptr_comp3_rd", PTR_RDATA, 8'h0C);

        // Asynchronous reset while a read strobe awaits ACK with writes queued.
        ack_en = 1'b0;
        RD_INC_EN = 1'b0;
        set_ptr(8'h10);
        cpu_read();
        cpu_write(8'h01);
        cpu_write(8'h02);
        n = 0;
        while (!PAL_R_STROBE && n < 20) begin tick(); n++; end
        check("rstb_seen", PAL_R_STROBE, 1);
        RESET_n = 1'b0;
        #2;
        check("arst_rstb", PAL_R_STROBE, 0);
        check("arst_busy", BUSY, 0);
        check("arst_ptr", PTR_RDATA, 8'h00);
        ack_en = 1'b1;
        tick();
        RESET_n = 1'b1;
        repeat (12) tick();
        check("post_rst_busy", BUSY, 0);
        check("post_rst_wstb", PAL_W_STROBE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
